uart_rx_core: RTL and testbench
===============================

# uart_rx_core

UART receive engine that sits directly on the serial `rx` line of the UART interface and produces the byte stream and error flags the rest of the design consumes. It synchronises the asynchronous line, detects and qualifies start bits, and samples 8 data bits LSB-first at mid-bit using a programmable divisor. It then checks optional even parity and the stop bit. Each completed frame is reported with a single-cycle `rx_valid` pulse, qualified by `frame_error` and `parity_error`.

## Interface
- `DATA_BITS`, 8: data bits per frame; fixed, not exposed for override.
- `MIN_DIV`, 4: smallest effective divisor; smaller `baud_rate` values are treated as `MIN_DIV`.
- `clk` input 1: single clock; all logic is clocked on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `rx` input 1: asynchronous serial line; idle high.
- `parity_en` input 1: 1 enables an even-parity bit between data and stop.
- `baud_rate` input 13: clock cycles per bit (divisor B).
- `rx_data` output 8: last received byte; held until the next frame completes.
- `rx_valid` output 1: one-cycle pulse marking a completed frame.
- `frame_error` output 1: one-cycle pulse coincident with `rx_valid`; the stop bit was sampled low.
- `parity_error` output 1: one-cycle pulse coincident with `rx_valid`; parity mismatch (only when `parity_en`).
- `busy` output 1: high in every state except IDLE.

## Operation
- **Reset values:** `rx_data`=0x00, `rx_valid`=0, `frame_error`=0, `parity_error`=0, `busy`=0. Both synchroniser flops reset to 1. State resets to IDLE and the counter to 0.
- **Synchroniser:** `rx` passes through 2 flops. All logic below uses the synchronised `rxs`.
- **Latching:** B = max(`baud_rate`, MIN_DIV) and `parity_en` are latched on start detection. Changes mid-frame have no effect.
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK.
- **IDLE:** when `rxs`=0, go to START and clear the counter.
- **START:** count to floor(B/2)-1, then sample.
  - `rxs`=1: false start; return to IDLE with no outputs.
  - `rxs`=0: go to DATA.
- **DATA:** count to B-1 and sample. Shift the sample in LSB-first. After bit 7, go to PARITY if `parity_en`, else STOP.
- **PARITY:** count to B-1 and sample. Error if XOR(data bits, parity bit) ≠ 0.
- **STOP:** count to B-1 and sample.
  - `rxs`=1: go to IDLE immediately, at mid-stop-bit, so back-to-back frames are accepted.
  - `rxs`=0: assert `frame_error` and go to BREAK.
- **BREAK:** wait until `rxs`=1, then go to IDLE. No start detection happens while in BREAK.
- **Frame reporting:** every frame that reaches its STOP sample produces `rx_valid`, including errored frames. `rx_data` is updated on the same cycle.
- **Counter:** 13-bit, cleared on every sample and every state change; it never wraps.
- **Reset mid-frame:** the partial frame is discarded and no pulse is emitted. The next start bit after reset is received normally.

## Timing
- **Notation:** T0 is the first cycle in which `rxs`=0 in IDLE; it falls 2 cycles after the raw `rx` falling edge. H = floor(B/2).
- **Sample points:**
  - start bit: T0+H;
  - data bit i: T0+H+(i+1)·B;
  - parity bit: T0+H+9·B;
  - stop bit: T0+H+9·B without parity, T0+H+10·B with parity.
- **Outputs:** `rx_valid`, `rx_data` and both error flags are registered. They are visible on the cycle after the stop sample and last exactly one cycle.
- **`busy`:** rises at T0+1 and falls on the cycle after the STOP→IDLE transition.

## Structure
- **Package `uart_rx_pkg`:** state enum `uart_rx_state_t`, and the constants `DATA_BITS` and `MIN_DIV`.
- **Sub-module `uart_sync2`:** 2-flop synchroniser with a reset value of 1, reusable by the TX loopback path.
- **Estimated size:** roughly 180 lines of RTL.

## Test plan
- **Basic frame:** B=16, no parity, send 0xA5. Expect `rx_valid` at T0+H+9·B+1 = T0+153 with `rx_data`=0xA5 and both error flags 0.
- **Parity:** B=16, `parity_en`=1, send 0x3C with parity bit 0. Expect `rx_valid` and no errors. Repeat with parity bit 1: expect `parity_error`=1 together with `rx_valid`.
- **Frame error and break:**
  - B=16, send 0x55 with the stop bit low: expect `frame_error`=1 with `rx_valid`.
  - Hold `rx` low for 40 more cycles: expect no further `rx_valid`.
  - Release `rx`, then send 0x12: expect it received cleanly.
- **Glitch rejection:** B=16, pulse `rx` low for 4 cycles. Expect no `rx_valid`, and `busy` to return to 0 within 10 cycles.
- **Back-to-back frames:** B=8, send 0x00 then 0xFF with no idle gap. Expect two `rx_valid` pulses, 80 cycles apart, carrying the correct data.
- **Reset mid-frame, then clamp check:**
  - Assert `rst_n`=0 during data bit 3, then release. Expect no pulse and all outputs at reset values.
  - Then send 0x81 with `baud_rate`=2. Expect it received as with B=4.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// The divisor clamp and the even-parity check live here so that the TX side can reuse them.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;
    localparam int MIN_DIV   = 4;
    localparam int DIV_W     = 13;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_rx_state_t;

    // Very small divisors leave no room to find mid-bit, so they are raised to MIN_DIV.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div);
        logic [DIV_W-1:0] v_min;
        logic [DIV_W-1:0] v_res;
        v_min = DIV_W'(MIN_DIV);
        if (div < v_min) begin
            v_res = v_min;
        end else begin
            v_res = div;
        end
        return v_res;
    endfunction

    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                             input logic                 par_bit);
        return ^{data, par_bit};
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an idle-high asynchronous line.
// It resets to 1, so a reset is never seen as a start bit.
module uart_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two-stage metastability filter with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: start qualification, mid-bit sampling, even parity and stop check.
// Every frame that reaches its stop sample is reported with a one-cycle rx_valid pulse.
module uart_rx_core
    import uart_rx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 parity_en,
    input  logic [DIV_W-1:0]     baud_rate,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    logic                 w_rxs;
    logic [DIV_W-1:0]     w_div_clamped;
    logic                 w_start_done;
    logic                 w_bit_done;

    uart_rx_state_t       r_state;
    logic [DIV_W-1:0]     r_cnt;
    logic [DIV_W-1:0]     r_start_last;
    logic [DIV_W-1:0]     r_bit_last;
    logic [BIT_IDX_W-1:0] r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_en;
    logic                 r_par_bit;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_busy;

    uart_sync2 u_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_async (rx),
        .o_sync  (w_rxs)
    );

    assign w_div_clamped = clamp_div(baud_rate);
    // The terminal counts are stored minus one, so each sample point is a plain equality test.
    assign w_start_done  = (r_cnt == r_start_last);
    assign w_bit_done    = (r_cnt == r_bit_last);

    // Receive FSM: the counter, the shift register and the registered frame report.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= DIV_W'(0);
            r_start_last <= DIV_W'(0);
            r_bit_last   <= DIV_W'(0);
            r_bit_idx    <= BIT_IDX_W'(0);
            r_shift      <= DATA_BITS'(0);
            r_par_en     <= 1'b0;
            r_par_bit    <= 1'b0;
            r_data       <= DATA_BITS'(0);
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rxs) begin
                        r_state      <= ST_START;
                        r_cnt        <= DIV_W'(0);
                        r_start_last <= (w_div_clamped >> 1) - DIV_W'(1);
                        r_bit_last   <= w_div_clamped - DIV_W'(1);
                        r_par_en     <= parity_en;
                        r_busy       <= 1'b1;
                    end else begin
                        r_cnt <= DIV_W'(0);
                    end
                end
                ST_START: begin
                    if (w_start_done) begin
                        r_cnt <= DIV_W'(0);
                        if (w_rxs) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= BIT_IDX_W'(0);
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_done) begin
                        r_cnt   <= DIV_W'(0);
                        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= r_par_en ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (w_bit_done) begin
                        r_cnt     <= DIV_W'(0);
                        r_par_bit <= w_rxs;
                        r_state   <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop-bit lets a back-to-back start edge be caught in IDLE.
                    if (w_bit_done) begin
                        r_cnt        <= DIV_W'(0);
                        r_valid      <= 1'b1;
                        r_data       <= r_shift;
                        r_parity_err <= r_par_en & parity_mismatch(r_shift, r_par_bit);
                        if (w_rxs) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (w_rxs) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= DIV_W'(0);
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= DIV_W'(0);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= DIV_W'(0);
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign frame_error  = r_frame_err;
    assign parity_error = r_parity_err;
    assign busy         = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomised self-checking bench for uart_rx_core: frames are predicted from the bit-level
// frame format and the sample-point arithmetic, then matched against the observed pulses.
module tb_uart_rx_core;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        parity_en;
    logic [12:0] baud_rate;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_error;
    logic        parity_error;
    logic        busy;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } evt_t;

    evt_t       exp_q[$];
    evt_t       obs_q[$];
    evt_t       mon_ev;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] last_data = 8'h00;

    uart_rx_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .parity_en    (parity_en),
        .baud_rate    (baud_rate),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_error  (frame_error),
        .parity_error (parity_error),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Record every reported frame; error flags must never appear without rx_valid.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            mon_ev.cyc  = cyc;
            mon_ev.data = rx_data;
            mon_ev.ferr = frame_error;
            mon_ev.perr = parity_error;
            obs_q.push_back(mon_ev);
        end else begin
            chk_eq("flag_without_valid", {30'd0, frame_error, parity_error}, 32'd0);
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at the current negedge and queues the predicted report.
    task automatic send_frame(input logic [7:0] data, input int br, input bit pen,
                              input bit par_ok, input bit stop_hi, input int hold_low,
                              input bit scramble);
        int   b;
        int   c0;
        int   nb;
        evt_t e;
        b  = (br < 4) ? 4 : br;
        nb = pen ? 10 : 9;
        baud_rate = 13'(br);
        parity_en = pen;
        rx        = 1'b0;
        c0        = cyc;
        for (int k = 1; k <= b; k++) begin
            @(negedge clk);
            if (k == 2) chk_eq("busy_before_t0", {31'd0, busy}, 32'd0);
            if (k == 3) chk_eq("busy_at_t0p1", {31'd0, busy}, 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            if (scramble && i == 1) begin
                baud_rate = 13'($urandom_range(0, 8191));
                parity_en = ~pen;
            end
            repeat (b) @(negedge clk);
        end
        if (pen) begin
            rx = (^data) ^ ~par_ok;
            repeat (b) @(negedge clk);
        end
        rx     = stop_hi;
        e.cyc  = c0 + 2 + (b / 2) + nb * b + 1;
        e.data = data;
        e.ferr = ~stop_hi;
        e.perr = pen & ~par_ok;
        exp_q.push_back(e);
        last_data = data;
        repeat (b) @(negedge clk);
        if (!stop_hi) begin
            repeat (hold_low) @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic compare_events(input string tag);
        int n;
        repeat (12) @(negedge clk);
        chk_eq({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk_eq({tag, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
            chk_eq({tag, "_data"}, {24'd0, obs_q[i].data}, {24'd0, exp_q[i].data});
            chk_eq({tag, "_ferr"}, {31'd0, obs_q[i].ferr}, {31'd0, exp_q[i].ferr});
            chk_eq({tag, "_perr"}, {31'd0, obs_q[i].perr}, {31'd0, exp_q[i].perr});
        end
        chk_eq({tag, "_data_hold"}, {24'd0, rx_data}, {24'd0, last_data});
        chk_eq({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        chk_eq({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        chk_eq({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        chk_eq({tag, "_frame_error"}, {31'd0, frame_error}, 32'd0);
        chk_eq({tag, "_parity_error"}, {31'd0, parity_error}, 32'd0);
        chk_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] mid;
        int         br;
        bit         pen;
        bit         pok;
        bit         shi;
        rst_n     = 1'b0;
        rx        = 1'b1;
        parity_en = 1'b0;
        baud_rate = 13'd16;
        repeat (4) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        idle(5);

        send_frame(8'hA5, 16, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        idle(3);
        compare_events("basic");

        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        idle(3);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        idle(3);
        compare_events("parity");

        send_frame(8'h55, 16, 1'b0, 1'b1, 1'b0, 40, 1'b0);
        idle(5);
        send_frame(8'h12, 16, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        idle(3);
        compare_events("break");

        baud_rate = 13'd16;
        parity_en = 1'b0;
        rx        = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) chk_eq("glitch_busy_rise", {31'd0, busy}, 32'd1);
        end
        idle(10);
        chk_eq("glitch_busy_fall", {31'd0, busy}, 32'd0);
        compare_events("glitch");

        send_frame(8'h00, 8, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        send_frame(8'hFF, 8, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        idle(3);
        compare_events("b2b");

        // Abort a frame halfway through data bit 3.
        mid       = 8'h5A;
        baud_rate = 13'd16;
        parity_en = 1'b0;
        rx        = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = mid[i];
            repeat (16) @(negedge clk);
        end
        rx = mid[3];
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("midreset");
        rst_n     = 1'b1;
        last_data = 8'h00;
        idle(10);
        compare_events("midreset");

        send_frame(8'h81, 2, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        idle(3);
        compare_events("clamp");

        for (int n = 0; n < 40; n++) begin
            rd  = 8'($urandom);
            br  = $urandom_range(0, 20);
            pen = 1'($urandom_range(0, 1));
            pok = ($urandom_range(0, 3) != 0);
            shi = ($urandom_range(0, 5) != 0);
            send_frame(rd, br, pen, pok, shi, $urandom_range(0, 30), 1'($urandom_range(0, 1)));
            idle(shi ? $urandom_range(0, 4) : $urandom_range(3, 6));
        end
        idle(3);
        compare_events("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
